scan_frame: RTL and testbench



---
 rtl/scan_pkg.sv | 44 ++++
 rtl/scan_trigger.sv | 21 ++
 rtl/scan_frame.sv | 113 +++++++++++
 tb/tb_scan_frame.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and constant helpers for the scan-out blocks.
// State enum, beat/width math and header bit ordering.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_t;

    localparam logic [7:0] DEF_HDR = 8'b0000_1010;

    function automatic int beats(input int width, input int lanes);
        return (width + lanes - 1) / lanes;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bit c of the result is the header bit sent on beat c.
    function automatic logic [7:0] hdr_order(input logic [7:0] pat,
                                             input int len);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < len)
                r = r | ((8'(pat >> (len - 1 - i)) & 8'h01) << i);
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_trigger.sv
// Rising-edge detector for a scan enable.
// Ports: clk, rst_n (sync, active-low), en in; trig = en & ~last_en out.
module scan_trigger
    import scan_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic trig
);

    logic last_en;

    always_ff @(posedge clk) begin
        if (!rst_n) last_en <= 1'b0;
        else        last_en <= en;
    end

    assign trig = en & ~last_en;

endmodule

// File: rtl/scan_frame.sv
// Serial scan-out engine: header then snapshot word over LANES pins.
// Ports: clk, rst_n, en, repeat_mode, scan_data in; scan_out, scan_valid, done out.
module scan_frame
    import scan_pkg::*;
#(
    parameter int         WIDTH       = 19,
    parameter int         LANES       = 1,
    parameter int         HDR_LEN     = 4,
    parameter logic [7:0] HDR_PATTERN = DEF_HDR,
    parameter bit         LSB_FIRST   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             repeat_mode,
    input  logic [WIDTH-1:0] scan_data,
    output logic [LANES-1:0] scan_out,
    output logic             scan_valid,
    output logic             done
);

    localparam int BEATS = beats(WIDTH, LANES);
    localparam int CW    = clog2(max3(BEATS, HDR_LEN, 2));
    localparam int OW    = BEATS * LANES;

    localparam state_t          START    = (HDR_LEN > 0) ? HDR : DATA;
    localparam logic [CW-1:0]   HDR_LAST = CW'((HDR_LEN > 0) ? HDR_LEN - 1 : 0);
    localparam logic [CW-1:0]   DAT_LAST = CW'(BEATS - 1);
    localparam logic [7:0]      HDR_REV  = hdr_order(HDR_PATTERN, HDR_LEN);

    logic             trig;
    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] snap, snap_n;
    logic [OW-1:0]    ord;
    logic [LANES-1:0] out_n;
    logic             hdr_bit;

    scan_trigger u_trig (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .trig  (trig)
    );

    // Next state describes the beat that will be on the pins next cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        snap_n  = snap;
        if (trig) begin
            snap_n  = scan_data;
            cnt_n   = '0;
            state_n = START;
        end else begin
            case (state)
                HDR: begin
                    if (cnt == HDR_LAST) begin
                        cnt_n   = '0;
                        state_n = DATA;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == DAT_LAST) begin
                        cnt_n = '0;
                        if (repeat_mode && en) begin
                            snap_n  = scan_data;
                            state_n = START;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Word laid out in transmit order, zero-padded to whole beats.
    always_comb begin
        ord     = OW'(LSB_FIRST ? snap_n : {<<{snap_n}});
        hdr_bit = |(HDR_REV & (8'h01 << cnt_n));
        out_n   = '0;
        case (state_n)
            HDR:     out_n = {LANES{hdr_bit}};
            DATA:    out_n = LANES'(ord >> (cnt_n * LANES));
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            snap       <= '0;
            scan_out   <= '0;
            scan_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            snap       <= snap_n;
            scan_out   <= out_n;
            scan_valid <= (state_n != IDLE);
            done       <= (state_n == DATA) && (cnt_n == DAT_LAST);
        end
    end

endmodule

// File: tb/tb_scan_frame.sv
// Self-checking bench for scan_frame.
// Three configurations share one stimulus stream against a queue model.
module tb_scan_frame;

    logic        clk = 1'b0;
    logic        rst_n, en, rep;
    logic [18:0] data;
    logic        o0, v0, d0;
    logic [3:0]  o1;
    logic        v1, d1;
    logic        o2, v2, d2;
    logic        mon;

    always #5 clk = ~clk;

    scan_frame u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .repeat_mode(rep),
        .scan_data(data), .scan_out(o0), .scan_valid(v0), .done(d0)
    );

    scan_frame #(.LANES(4), .HDR_LEN(0)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .repeat_mode(rep),
        .scan_data(data), .scan_out(o1), .scan_valid(v1), .done(d1)
    );

    scan_frame #(.LSB_FIRST(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .repeat_mode(rep),
        .scan_data(data), .scan_out(o2), .scan_valid(v2), .done(d2)
    );

    typedef struct {
        logic [7:0] out;
        logic       valid;
        logic       done;
    } beat_t;

    typedef beat_t bq_t[$];

    typedef struct {
        int          inst;
        logic [18:0] data;
        int          k;
        logic [7:0]  out;
        logic        valid;
        logic        done;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    function automatic int p_lanes(input int k);
        return (k == 1) ? 4 : 1;
    endfunction

    function automatic int p_hdr(input int k);
        return (k == 1) ? 0 : 4;
    endfunction

    function automatic bit p_lsb(input int k);
        return (k != 2);
    endfunction

    // Whole frame as the list of beats seen on the pins.
    function automatic bq_t frame(input int k, input logic [18:0] w);
        bq_t        f;
        beat_t      b;
        int         l, h, nb, bi;
        logic [7:0] pat, msk;
        pat = 8'b0000_1010;
        l   = p_lanes(k);
        h   = p_hdr(k);
        nb  = (19 + l - 1) / l;
        msk = 8'((1 << l) - 1);
        for (int j = 0; j < h; j++) begin
            b.out   = pat[h - 1 - j] ? msk : 8'h00;
            b.valid = 1'b1;
            b.done  = 1'b0;
            f.push_back(b);
        end
        for (int c = 0; c < nb; c++) begin
            b.out = 8'h00;
            for (int i = 0; i < l; i++) begin
                bi = c * l + i;
                if (bi < 19) b.out[i] = p_lsb(k) ? w[bi] : w[18 - bi];
            end
            b.valid = 1'b1;
            b.done  = (c == nb - 1);
            f.push_back(b);
        end
        return f;
    endfunction

    bq_t  mq [3];
    logic m_last;

    always @(posedge clk) begin
        beat_t b;
        logic  trig;
        if (!rst_n) begin
            m_last = 1'b0;
            for (int k = 0; k < 3; k++) mq[k].delete();
        end else begin
            trig   = en && !m_last;
            m_last = en;
            for (int k = 0; k < 3; k++) begin
                if (trig) begin
                    mq[k] = frame(k, data);
                end else if (mq[k].size() > 0) begin
                    b = mq[k].pop_front();
                    if (b.done && rep && en) mq[k] = frame(k, data);
                end
            end
        end
    end

    function automatic beat_t got(input int k);
        beat_t g;
        case (k)
            0:       g = '{{7'b0, o0}, v0, d0};
            1:       g = '{{4'b0, o1}, v1, d1};
            default: g = '{{7'b0, o2}, v2, d2};
        endcase
        return g;
    endfunction

    task automatic chk(input string nm, input int k,
                       input beat_t g, input beat_t e);
        n_chk++;
        if (g.out !== e.out || g.valid !== e.valid || g.done !== e.done) begin
            n_fail++;
            $display("FAIL %s u%0d: got out=%h valid=%b done=%b, expected out=%h valid=%b done=%b",
                     nm, k, g.out, g.valid, g.done, e.out, e.valid, e.done);
        end
    endtask

    task automatic exp_at(input string nm, input int k, input logic [7:0] o,
                          input logic v, input logic d);
        beat_t e;
        e = '{o, v, d};
        chk(nm, k, got(k), e);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (mon) begin
            for (int k = 0; k < 3; k++) begin
                e = '{8'h00, 1'b0, 1'b0};
                if (mq[k].size() > 0) e = mq[k][0];
                chk("model", k, got(k), e);
            end
        end
    end

    initial begin
        vec_t tbl[$];
        int   saw, found, cnt;

        rst_n = 1'b0;
        en    = 1'b0;
        rep   = 1'b0;
        data  = '0;
        mon   = 1'b0;
        repeat (3) @(negedge clk);
        mon = 1'b1;
        for (int k = 0; k < 3; k++) exp_at("reset", k, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;

        tbl.push_back('{0, 19'h2A5C3, 0,  8'h01, 1'b1, 1'b0});
        tbl.push_back('{0, 19'h2A5C3, 1,  8'h00, 1'b1, 1'b0});
        tbl.push_back('{0, 19'h2A5C3, 2,  8'h01, 1'b1, 1'b0});
        tbl.push_back('{0, 19'h2A5C3, 3,  8'h00, 1'b1, 1'b0});
        tbl.push_back('{0, 19'h2A5C3, 4,  8'h01, 1'b1, 1'b0});
        tbl.push_back('{0, 19'h2A5C3, 5,  8'h01, 1'b1, 1'b0});
        tbl.push_back('{0, 19'h2A5C3, 6,  8'h00, 1'b1, 1'b0});
        tbl.push_back('{0, 19'h2A5C3, 10, 8'h01, 1'b1, 1'b0});
        tbl.push_back('{0, 19'h2A5C3, 17, 8'h01, 1'b1, 1'b0});
        tbl.push_back('{0, 19'h2A5C3, 21, 8'h01, 1'b1, 1'b0});
        tbl.push_back('{0, 19'h2A5C3, 22, 8'h00, 1'b1, 1'b1});
        tbl.push_back('{0, 19'h2A5C3, 23, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{1, 19'h7FFFF, 0,  8'h0F, 1'b1, 1'b0});
        tbl.push_back('{1, 19'h7FFFF, 3,  8'h0F, 1'b1, 1'b0});
        tbl.push_back('{1, 19'h7FFFF, 4,  8'h07, 1'b1, 1'b1});
        tbl.push_back('{1, 19'h7FFFF, 5,  8'h00, 1'b0, 1'b0});
        tbl.push_back('{2, 19'h40000, 0,  8'h01, 1'b1, 1'b0});
        tbl.push_back('{2, 19'h40000, 4,  8'h01, 1'b1, 1'b0});
        tbl.push_back('{2, 19'h40000, 5,  8'h00, 1'b1, 1'b0});
        tbl.push_back('{2, 19'h40000, 22, 8'h00, 1'b1, 1'b1});
        tbl.push_back('{2, 19'h40000, 23, 8'h00, 1'b0, 1'b0});

        foreach (tbl[j]) begin
            en  = 1'b0;
            rep = 1'b0;
            repeat (30) @(negedge clk);
            data = tbl[j].data;
            en   = 1'b1;
            @(negedge clk);
            en = 1'b0;
            repeat (tbl[j].k) @(negedge clk);
            exp_at("table", tbl[j].inst, tbl[j].out,
                   tbl[j].valid, tbl[j].done);
        end

        // Retrigger at data beat 6 aborts the frame without done.
        repeat (30) @(negedge clk);
        data = 19'h2A5C3;
        en   = 1'b1;
        @(negedge clk);
        en  = 1'b0;
        saw = 0;
        for (int c = 0; c < 10; c++) begin
            if (d0) saw++;
            @(negedge clk);
        end
        if (d0) saw++;
        data = 19'h00001;
        en   = 1'b1;
        @(negedge clk);
        en = 1'b0;
        exp_at("retrig_hdr", 0, 8'h01, 1'b1, 1'b0);
        exp_at("retrig_l4", 1, 8'h01, 1'b1, 1'b0);
        n_chk++;
        if (saw != 0) begin
            n_fail++;
            $display("FAIL retrig_done: got %0d done pulses, expected 0", saw);
        end
        repeat (4) @(negedge clk);
        exp_at("retrig_b0", 0, 8'h01, 1'b1, 1'b0);
        @(negedge clk);
        exp_at("retrig_b1", 0, 8'h00, 1'b1, 1'b0);

        // Repeat mode: back-to-back frames with a fresh capture.
        repeat (30) @(negedge clk);
        rep  = 1'b1;
        data = 19'h11111;
        en   = 1'b1;
        @(negedge clk);
        repeat (4) @(negedge clk);
        exp_at("rep_f1b0", 0, 8'h01, 1'b1, 1'b0);
        data  = 19'h22222;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            @(negedge clk);
            if (d0) found = 1;
        end
        n_chk++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL rep_wait: got no done within 40 cycles, expected one");
        end
        exp_at("rep_last", 0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        exp_at("rep_gap", 0, 8'h01, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        exp_at("rep_f2b0", 0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        exp_at("rep_f2b1", 0, 8'h01, 1'b1, 1'b0);
        en  = 1'b0;
        rep = 1'b0;

        // Reset at data beat 3 aborts; nothing restarts on its own.
        repeat (40) @(negedge clk);
        data = 19'h2A5C3;
        en   = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) exp_at("rst_mid", k, 8'h00, 1'b0, 1'b0);
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (v0 || v1 || v2) cnt++;
        end
        n_chk++;
        if (cnt != 0) begin
            n_fail++;
            $display("FAIL rst_idle: got %0d valid cycles, expected 0", cnt);
        end
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        exp_at("rst_new", 0, 8'h01, 1'b1, 1'b0);

        // Random traffic against the queue model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 14) == 0) en = ~en;
            if ($urandom_range(0, 49) == 0) rep = ~rep;
            data = 19'($urandom);
        end
        rst_n = 1'b1;
        en    = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
